// File: rtl/yolo_layer_pkg.sv
// Shared definitions for the YOLO-layer class-argmax path: lane geometry and
// the {eligible, value, index} record that flows through the compare tree.
package yolo_layer_pkg;

    localparam int LANE_W     = 8;
    localparam int LANES      = 8;
    localparam int BOX_FIELDS = 5;

    // One compare-tree candidate: an ineligible candidate never wins a compare.
    typedef struct packed {
        logic              elig;
        logic [LANE_W-1:0] value;
        logic [2:0]        index;
    } cmax_pair_t;

    // Lanes of the final beat of an anchor that still carry class channels.
    function automatic logic [LANES-1:0] last_beat_class_lanes(input int beats,
                                                                input int class_num);
        logic [LANES-1:0] m;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            m[k] = (((beats - 1) * LANES) + k) < (BOX_FIELDS + class_num);
        end
        return m;
    endfunction

endpackage

// File: rtl/yolo_cmax8_gen_if.sv
// Beat stream in, tagged argmax bus out, between the YOLO-layer upstream and
// the per-anchor running-argmax accumulators.
interface yolo_cmax8_gen_if;
    import yolo_layer_pkg::*;

    logic                    yolo_layer_finish;
    logic                    in_valid;
    logic [LANES*LANE_W-1:0] in_data;
    logic                    en;
    logic [3:0]              trans_cnt;
    logic [1:0]              anchor_sel_t;
    logic [LANE_W-1:0]       cmax8_value_x;
    logic [2:0]              cmax8_index_x;
    logic                    anchor_done;

    modport master (
        output yolo_layer_finish, in_valid, in_data,
        input  en, trans_cnt, anchor_sel_t, cmax8_value_x, cmax8_index_x, anchor_done
    );

    modport slave (
        input  yolo_layer_finish, in_valid, in_data,
        output en, trans_cnt, anchor_sel_t, cmax8_value_x, cmax8_index_x, anchor_done
    );

endinterface

// File: rtl/cmax_pair_sel.sv
// Two-input {value, index} select used as a node of the argmax tree.
// The left input keeps ties so the lowest lane index survives.
module cmax_pair_sel
    import yolo_layer_pkg::*;
(
    input  cmax_pair_t a_i,
    input  cmax_pair_t b_i,
    output cmax_pair_t y_o
);

    // Right side wins only if eligible and strictly larger, or if left is ineligible.
    always_comb begin
        y_o = a_i;
        if (b_i.elig && (!a_i.elig || (b_i.value > a_i.value))) begin
            y_o = b_i;
        end
    end

endmodule

// File: rtl/yolo_cmax8_gen.sv
// Producer side of the YOLO-layer class-argmax path: tags each 64-bit beat
// with its beat/anchor numbers, masks box/obj (and optionally pad) lanes and
// reduces the eligible lanes to a {max value, lane index} pair in two stages.
// Optional feature macro: YOLO_CMAX8_PAD_MASK_EN masks last-beat pad lanes.
module yolo_cmax8_gen
    import yolo_layer_pkg::*;
#(
    parameter int CLASS_NUM        = 80,
    parameter int BEATS_PER_ANCHOR = 11,
    parameter int NUM_ANCHORS      = 3
) (
    input logic             clk,
    input logic             rst_n,
    yolo_cmax8_gen_if.slave bus
);

    localparam logic [3:0]       LAST_BEAT        = 4'(BEATS_PER_ANCHOR);
    localparam logic [1:0]       LAST_ANCHOR      = 2'(NUM_ANCHORS);
    localparam logic [LANES-1:0] FIRST_BEAT_LANES = ~LANES'((1 << BOX_FIELDS) - 1);
`ifdef YOLO_CMAX8_PAD_MASK_EN
    localparam logic [LANES-1:0] LAST_BEAT_LANES  =
        last_beat_class_lanes(BEATS_PER_ANCHOR, CLASS_NUM);
`endif

    // Reject parameter sets the counters and masks cannot represent.
    if (CLASS_NUM < 3) begin : g_bad_class_num
        $error("yolo_cmax8_gen: CLASS_NUM must be at least 3");
    end
    if ((BEATS_PER_ANCHOR > 15) ||
        (BEATS_PER_ANCHOR != ((BOX_FIELDS + CLASS_NUM + LANES - 1) / LANES))) begin : g_bad_beats
        $error("yolo_cmax8_gen: BEATS_PER_ANCHOR must be ceil((5+CLASS_NUM)/8) and at most 15");
    end
    if ((NUM_ANCHORS < 1) || (NUM_ANCHORS > 3)) begin : g_bad_anchors
        $error("yolo_cmax8_gen: NUM_ANCHORS must be 1..3");
    end

    logic                    flush;
    logic [3:0]              beat_cnt_q, beat_cnt_d;
    logic [1:0]              anc_cnt_q, anc_cnt_d;

    logic                    in_vld_q;
    logic [LANES*LANE_W-1:0] in_data_q;
    logic [3:0]              in_beat_q;
    logic [1:0]              in_anc_q;
    logic                    in_last;
    logic [LANES-1:0]        elig_mask;

    cmax_pair_t              lane_pair [LANES];
    cmax_pair_t              lvl1_pair [4];
    cmax_pair_t              lvl2_pair [2];

    logic                    s1_vld_q;
    cmax_pair_t              s1_pair_q [2];
    logic [3:0]              s1_beat_q;
    logic [1:0]              s1_anc_q;
    logic                    s1_last_q;
    cmax_pair_t              final_pair;
    logic                    out_upd;

    logic                    en_q;
    logic                    done_q;
    logic [3:0]              trans_q;
    logic [1:0]              anc_sel_q;
    logic [LANE_W-1:0]       value_q;
    logic [2:0]              index_q;

    // A finishing layer and reset both drop every in-flight beat and any beat presented now.
    assign flush = !rst_n || bus.yolo_layer_finish;

    // Next beat/anchor numbers: beat wraps at the anchor length, anchor wraps per grid cell.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        anc_cnt_d  = anc_cnt_q;
        if (bus.in_valid) begin
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d = 4'd1;
                anc_cnt_d  = (anc_cnt_q == LAST_ANCHOR) ? 2'd1 : anc_cnt_q + 2'd1;
            end else begin
                beat_cnt_d = beat_cnt_q + 4'd1;
            end
        end
    end

    // Input beat/anchor counters, restarting at 1/1 on reset or layer finish.
    always_ff @(posedge clk) begin
        if (flush) begin
            beat_cnt_q <= 4'd1;
            anc_cnt_q  <= 2'd1;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            anc_cnt_q  <= anc_cnt_d;
        end
    end

    // Capture the accepted beat together with its beat/anchor tag.
    always_ff @(posedge clk) begin
        if (flush) begin
            in_vld_q <= 1'b0;
        end else begin
            in_vld_q <= bus.in_valid;
        end
        if (bus.in_valid) begin
            in_data_q <= bus.in_data;
            in_beat_q <= beat_cnt_q;
            in_anc_q  <= anc_cnt_q;
        end
    end

    assign in_last = (in_beat_q == LAST_BEAT);

    // Lanes allowed to compete: box/obj lanes of beat 1 never do, pad lanes optionally not.
    always_comb begin
        elig_mask = '1;
        if (in_beat_q == 4'd1) begin
            elig_mask = elig_mask & FIRST_BEAT_LANES;
        end
`ifdef YOLO_CMAX8_PAD_MASK_EN
        if (in_last) begin
            elig_mask = elig_mask & LAST_BEAT_LANES;
        end
`endif
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_pair[k] = '{elig:  elig_mask[k],
                                value: in_data_q[k*LANE_W +: LANE_W],
                                index: 3'(k)};
    end

    for (genvar k = 0; k < 4; k++) begin : g_lvl1
        cmax_pair_sel u_sel (
            .a_i (lane_pair[2*k]),
            .b_i (lane_pair[2*k+1]),
            .y_o (lvl1_pair[k])
        );
    end

    for (genvar k = 0; k < 2; k++) begin : g_lvl2
        cmax_pair_sel u_sel (
            .a_i (lvl1_pair[2*k]),
            .b_i (lvl1_pair[2*k+1]),
            .y_o (lvl2_pair[k])
        );
    end

    // Stage 1 register: the two half-tree winners plus the beat's tag.
    always_ff @(posedge clk) begin
        if (flush) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= in_vld_q;
        end
        if (in_vld_q) begin
            s1_pair_q[0] <= lvl2_pair[0];
            s1_pair_q[1] <= lvl2_pair[1];
            s1_beat_q    <= in_beat_q;
            s1_anc_q     <= in_anc_q;
            s1_last_q    <= in_last;
        end
    end

    cmax_pair_sel u_sel_final (
        .a_i (s1_pair_q[0]),
        .b_i (s1_pair_q[1]),
        .y_o (final_pair)
    );

    // Every beat has at least one eligible lane, so the elig term only guards against a bad config.
    assign out_upd = s1_vld_q && !bus.yolo_layer_finish && final_pair.elig;

    // Output register: single-cycle en per beat, data held between beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            trans_q   <= 4'd0;
            anc_sel_q <= 2'd0;
            value_q   <= '0;
            index_q   <= 3'd0;
        end else begin
            en_q   <= s1_vld_q && !bus.yolo_layer_finish;
            done_q <= s1_vld_q && !bus.yolo_layer_finish && s1_last_q;
            if (out_upd) begin
                trans_q   <= s1_beat_q;
                anc_sel_q <= s1_anc_q;
                value_q   <= final_pair.value;
                index_q   <= final_pair.index;
            end
        end
    end

    assign bus.en            = en_q;
    assign bus.anchor_done   = done_q;
    assign bus.trans_cnt     = trans_q;
    assign bus.anchor_sel_t  = anc_sel_q;
    assign bus.cmax8_value_x = value_q;
    assign bus.cmax8_index_x = index_q;

endmodule

// File: tb/tb_yolo_cmax8_gen.sv
// Self-checking bench for yolo_cmax8_gen: a table of directed beats, hand-written
// finish/reset sequences and a randomized run, all checked every cycle against a
// channel-level reference model with a 2-cycle delivery schedule.
module tb_yolo_cmax8_gen;
    import yolo_layer_pkg::*;

    localparam int CN  = 80;
    localparam int BPA = 11;
    localparam int NA  = 3;

    logic clk = 1'b0;
    logic rst_n;

    yolo_cmax8_gen_if bus ();

    yolo_cmax8_gen #(
        .CLASS_NUM        (CN),
        .BEATS_PER_ANCHOR (BPA),
        .NUM_ANCHORS      (NA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       done;
        logic [3:0] trans;
        logic [1:0] anc;
        logic [7:0] val;
        logic [2:0] idx;
    } outRec_t;

    typedef struct {
        int      due;
        outRec_t o;
    } pendBeat_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  expVal;
        logic [2:0]  expIdx;
    } vector_t;

    pendBeat_t expQ[$];
    outRec_t   held;
    int        cyc = 0;
    int        mBeat = 1;
    int        mAnc = 1;
    int        testsRun = 0;
    int        testsFailed = 0;
    string     phase = "reset";
    vector_t   tbl[BPA];

    // Argmax over the class channels carried by one beat, from channel numbering alone.
    function automatic outRec_t refBeat(logic [63:0] d, int beat, int anc);
        outRec_t r;
        int best;
        int bestVal;
        int ch;
        int v;
        best = -1;
        bestVal = 0;
        for (int k = 0; k < 8; k++) begin
            ch = (beat - 1) * 8 + k;
            v = int'(d[8*k +: 8]);
            if (ch < 5) continue;
`ifdef YOLO_CMAX8_PAD_MASK_EN
            if (ch >= 5 + CN) continue;
`endif
            if (best < 0 || v > bestVal) begin
                best = k;
                bestVal = v;
            end
        end
        r.en    = 1'b1;
        r.done  = (beat == BPA);
        r.trans = 4'(beat);
        r.anc   = 2'(anc);
        r.val   = 8'(bestVal);
        r.idx   = 3'(best);
        return r;
    endfunction

    task automatic compareRec(string name, outRec_t got, outRec_t exp);
        testsRun++;
        if (got.en !== exp.en || got.done !== exp.done || got.trans !== exp.trans ||
            got.anc !== exp.anc || got.val !== exp.val || got.idx !== exp.idx) begin
            testsFailed++;
            $display("[TB] FAIL %s cyc=%0d got en=%b done=%b trans=%0d anc=%0d val=%h idx=%0d, expected en=%b done=%b trans=%0d anc=%0d val=%h idx=%0d",
                     name, cyc, got.en, got.done, got.trans, got.anc, got.val, got.idx,
                     exp.en, exp.done, exp.trans, exp.anc, exp.val, exp.idx);
        end
    endtask

    function automatic outRec_t sampleDut();
        outRec_t g;
        g.en    = bus.en;
        g.done  = bus.anchor_done;
        g.trans = bus.trans_cnt;
        g.anc   = bus.anchor_sel_t;
        g.val   = bus.cmax8_value_x;
        g.idx   = bus.cmax8_index_x;
        return g;
    endfunction

    // Apply the inputs that were present at the edge just taken to the model.
    task automatic modelEdge();
        pendBeat_t p;
        if (!rst_n) begin
            expQ.delete();
            held = '{en: 1'b0, done: 1'b0, trans: 4'd0, anc: 2'd0, val: 8'd0, idx: 3'd0};
            mBeat = 1;
            mAnc = 1;
        end else if (bus.yolo_layer_finish) begin
            expQ.delete();
            mBeat = 1;
            mAnc = 1;
        end else if (bus.in_valid) begin
            p.due = cyc + 2;
            p.o = refBeat(bus.in_data, mBeat, mAnc);
            expQ.push_back(p);
            if (mBeat == BPA) begin
                mBeat = 1;
                mAnc = (mAnc == NA) ? 1 : mAnc + 1;
            end else begin
                mBeat++;
            end
        end
    endtask

    task automatic checkOutput();
        outRec_t exp;
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
            exp = expQ.pop_front().o;
            held = exp;
        end else begin
            exp = held;
            exp.en = 1'b0;
            exp.done = 1'b0;
        end
        compareRec(phase, sampleDut(), exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        modelEdge();
        checkOutput();
    endtask

    task automatic applyStimulus(logic v, logic [63:0] d, logic fin, logic rn);
        bus.in_valid = v;
        bus.in_data = d;
        bus.yolo_layer_finish = fin;
        rst_n = rn;
        tick();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
    endtask

    function automatic logic [63:0] rndData();
        logic [63:0] d;
        d = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) d = d & 64'h0303030303030303;
        return d;
    endfunction

    // Feed one beat after a restart and require it to come out as beat 1 of anchor 1.
    task automatic expectFirstBeat(string name, logic [63:0] d);
        outRec_t exp;
        applyStimulus(1'b1, d, 1'b0, 1'b1);
        idle(2);
        exp = refBeat(d, 1, 1);
        compareRec(name, sampleDut(), exp);
    endtask

    initial begin
        outRec_t exp;
        logic [63:0] d;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 64'd0;
        bus.yolo_layer_finish = 1'b0;

        tbl[0]  = '{64'h203010FFFFFFFFFF, 8'h30, 3'd6};
        tbl[1]  = '{64'h7F7F7F7F7F7F7F7F, 8'h7F, 3'd0};
        tbl[2]  = '{64'h0102030405060708, 8'h08, 3'd0};
        tbl[3]  = '{64'h0000000000000000, 8'h00, 3'd0};
        tbl[4]  = '{64'hFF00000000000000, 8'hFF, 3'd7};
        tbl[5]  = '{64'h00000000000000FE, 8'hFE, 3'd0};
        tbl[6]  = '{64'h0000900000000000, 8'h90, 3'd5};
        tbl[7]  = '{64'h0000000080800000, 8'h80, 3'd2};
        tbl[8]  = '{64'h0000000000000100, 8'h01, 3'd1};
        tbl[9]  = '{64'h00000000AA000000, 8'hAA, 3'd3};
`ifdef YOLO_CMAX8_PAD_MASK_EN
        tbl[10] = '{64'hF0F0F00504030201, 8'h05, 3'd4};
`else
        tbl[10] = '{64'hF0F0F00504030201, 8'hF0, 3'd5};
`endif

        phase = "reset";
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);

        phase = "table";
        for (int i = 0; i < BPA; i++) begin
            applyStimulus(1'b1, tbl[i].data, 1'b0, 1'b1);
            idle(2);
            exp = '{en: 1'b1, done: (i == BPA - 1), trans: 4'(i + 1), anc: 2'd1,
                    val: tbl[i].expVal, idx: tbl[i].expIdx};
            compareRec("table_vec", sampleDut(), exp);
        end

        phase = "stream34";
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3 * BPA; i++) applyStimulus(1'b1, rndData(), 1'b0, 1'b1);
        d = rndData();
        applyStimulus(1'b1, d, 1'b0, 1'b1);
        idle(2);
        compareRec("beat34_wrap", sampleDut(), refBeat(d, 1, 1));

        phase = "finish_gap";
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < BPA + 4; i++) applyStimulus(1'b1, rndData(), 1'b0, 1'b1);
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b1);
        idle(1);
        expectFirstBeat("finish_restart", rndData());

        phase = "finish_coincident";
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, rndData(), 1'b0, 1'b1);
        applyStimulus(1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1);
        expectFirstBeat("finish_drop", rndData());

        phase = "reset_mid";
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, rndData(), 1'b0, 1'b1);
        applyStimulus(1'b1, rndData(), 1'b0, 1'b0);
        expectFirstBeat("reset_restart", rndData());

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, rndData(),
                          $urandom_range(0, 59) == 0, $urandom_range(0, 149) != 0);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
